// File: rtl/sound_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : sound_scheduler_pkg
// Brief  : Shared types and constants for the sound scheduler and its SFX ROM.
// Rev    : 1.0  initial release
// ============================================================================
package sound_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUSIC = 2'd1,
    ST_SFX   = 2'd2
  } state_t;

  // SFX IDs double as priority: a larger ID preempts a smaller one
  localparam logic [1:0] c_SFX_ROTATE     = 2'd0;
  localparam logic [1:0] c_SFX_DROP       = 2'd1;
  localparam logic [1:0] c_SFX_LINE_CLEAR = 2'd2;
  localparam logic [1:0] c_SFX_GAME_OVER  = 2'd3;

  localparam logic [10:0] c_HZ_C4  = 11'd262;
  localparam logic [10:0] c_HZ_E4  = 11'd330;
  localparam logic [10:0] c_HZ_GS4 = 11'd415;
  localparam logic [10:0] c_HZ_A4  = 11'd440;
  localparam logic [10:0] c_HZ_B4  = 11'd494;
  localparam logic [10:0] c_HZ_C5  = 11'd523;
  localparam logic [10:0] c_HZ_D5  = 11'd587;
  localparam logic [10:0] c_HZ_E5  = 11'd659;
  localparam logic [10:0] c_HZ_G5  = 11'd784;
  localparam logic [10:0] c_HZ_B5  = 11'd988;
  localparam logic [10:0] c_HZ_C6  = 11'd1047;

  localparam int c_DEFAULT_MUSIC_TICK = 25_000_000;
  localparam int c_DEFAULT_SFX_TICK   = 2_500_000;

  function automatic logic [1:0] f_highest(input logic [3:0] p);
    if (p[3])      return 2'd3;
    else if (p[2]) return 2'd2;
    else if (p[1]) return 2'd1;
    else           return 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sound_scheduler_sfx_rom.sv
`default_nettype none
// ============================================================================
// Module : sfx_rom
// Brief  : Sound-effect note table: (sfx_id, note index) -> (hz, last note).
// Rev    : 1.0  initial release
// ============================================================================
module sfx_rom
  import sound_scheduler_pkg::*;
(
  input  logic [1:0]  sfx_id,
  input  logic [2:0]  note_idx,
  output logic [10:0] hz,
  output logic        last_note
);

  logic [2:0] w_n_notes;

  always_comb begin
    hz        = '0;
    w_n_notes = 3'd1;
    case (sfx_id)
      c_SFX_ROTATE: begin
        w_n_notes = 3'd2;
        case (note_idx)
          3'd0:    hz = c_HZ_G5;
          3'd1:    hz = c_HZ_B5;
          default: hz = '0;
        endcase
      end
      c_SFX_DROP: begin
        w_n_notes = 3'd2;
        case (note_idx)
          3'd0:    hz = c_HZ_E4;
          3'd1:    hz = c_HZ_C4;
          default: hz = '0;
        endcase
      end
      c_SFX_LINE_CLEAR: begin
        w_n_notes = 3'd4;
        case (note_idx)
          3'd0:    hz = c_HZ_C5;
          3'd1:    hz = c_HZ_E5;
          3'd2:    hz = c_HZ_G5;
          3'd3:    hz = c_HZ_C6;
          default: hz = '0;
        endcase
      end
      default: begin
        w_n_notes = 3'd6;
        case (note_idx)
          3'd0:    hz = c_HZ_E5;
          3'd1:    hz = c_HZ_D5;
          3'd2:    hz = c_HZ_C5;
          3'd3:    hz = c_HZ_B4;
          3'd4:    hz = c_HZ_A4;
          3'd5:    hz = c_HZ_GS4;
          default: hz = '0;
        endcase
      end
    endcase
    last_note = (note_idx >= w_n_notes - 3'd1);
  end

endmodule
`default_nettype wire

// File: rtl/sound_scheduler.sv
`default_nettype none
// ============================================================================
// Module : sound_scheduler
// Brief  : Arbitrates background melody and prioritised sound effects onto one
//          shared tone generator.
// Rev    : 1.0  initial release
// ============================================================================
module sound_scheduler
  import sound_scheduler_pkg::*;
#(
  parameter int MUSIC_TICK = c_DEFAULT_MUSIC_TICK,
  parameter int SFX_TICK   = c_DEFAULT_SFX_TICK,
  parameter int MUSIC_LEN  = 75
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        music_en,
  input  logic [3:0]  sfx_req,
  input  logic [10:0] music_hz,
  input  logic [2:0]  volume,
  output logic [6:0]  music_step,
  output logic [10:0] tone_hz,
  output logic [2:0]  tone_level,
  output logic        sfx_active,
  output logic [1:0]  sfx_id
);

  localparam int c_CNT_MAX = (MUSIC_TICK > SFX_TICK) ? MUSIC_TICK : SFX_TICK;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CW-1:0] c_MUSIC_RELOAD = c_CW'(MUSIC_TICK - 1);
  localparam logic [c_CW-1:0] c_SFX_RELOAD   = c_CW'(SFX_TICK - 1);
  localparam logic [6:0]      c_LAST_STEP    = 7'(MUSIC_LEN - 1);

  state_t            r_state, w_state_nx;
  logic [3:0]        r_pending, w_pending_nx;
  logic              r_muted, w_muted_nx, w_mute_set;
  logic [c_CW-1:0]   r_cnt, w_cnt_nx;
  logic [6:0]        r_step, w_step_nx;
  logic [1:0]        r_sfx_id, w_sfx_id_nx;
  logic [2:0]        r_note_idx, w_note_idx_nx;
  logic              r_note_last;
  logic [10:0]       r_tone, w_tone_nx;
  logic [2:0]        r_level;
  logic              r_active;
  logic [1:0]        w_hi;
  logic              w_any, w_preempt, w_expire, w_start;
  logic [10:0]       w_rom_hz;
  logic              w_rom_last;

  assign w_hi      = f_highest(r_pending);
  assign w_any     = |r_pending;
  assign w_preempt = w_any && (r_state != ST_SFX || w_hi > r_sfx_id);
  assign w_expire  = (r_cnt == '0);

  // ROM is addressed with the next note so tone_hz and last flag can be registered
  sfx_rom u_sfx_rom (
    .sfx_id    (w_sfx_id_nx),
    .note_idx  (w_note_idx_nx),
    .hz        (w_rom_hz),
    .last_note (w_rom_last)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_sfx_id_nx   = r_sfx_id;
    w_note_idx_nx = r_note_idx;
    w_step_nx     = r_step;
    w_cnt_nx      = w_expire ? '0 : r_cnt - c_CW'(1);
    w_start       = 1'b0;
    w_mute_set    = 1'b0;
    w_tone_nx     = '0;

    if (w_preempt) begin
      w_start = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (music_en && !r_muted) begin
            w_state_nx = ST_MUSIC;
            w_cnt_nx   = c_MUSIC_RELOAD;
          end
        end
        ST_MUSIC: begin
          if (!music_en) begin
            w_state_nx = ST_IDLE;
          end else if (w_expire) begin
            w_step_nx = (r_step == c_LAST_STEP) ? 7'd0 : r_step + 7'd1;
            w_cnt_nx  = c_MUSIC_RELOAD;
          end
        end
        ST_SFX: begin
          if (w_expire && !r_note_last) begin
            w_note_idx_nx = r_note_idx + 3'd1;
            w_cnt_nx      = c_SFX_RELOAD;
          end else if (w_expire) begin
            w_mute_set = (r_sfx_id == c_SFX_GAME_OVER);
            if (w_any) begin
              w_start = 1'b1;
            end else if (music_en && !r_muted && !w_mute_set) begin
              w_state_nx = ST_MUSIC;
              w_cnt_nx   = c_MUSIC_RELOAD;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end

    if (w_start) begin
      w_state_nx    = ST_SFX;
      w_sfx_id_nx   = w_hi;
      w_note_idx_nx = 3'd0;
      w_cnt_nx      = c_SFX_RELOAD;
    end

    if (!music_en) w_step_nx = 7'd0;

    w_pending_nx = (r_pending & ~(w_start ? (4'b0001 << w_hi) : 4'b0000)) | sfx_req;
    w_muted_nx   = w_mute_set | (r_muted & music_en);

    // In MUSIC the tone follows the external ROM for the step held before this edge
    case (w_state_nx)
      ST_SFX:   w_tone_nx = w_rom_hz;
      ST_MUSIC: w_tone_nx = music_hz;
      default:  w_tone_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_muted     <= 1'b0;
      r_cnt       <= '0;
      r_step      <= '0;
      r_sfx_id    <= '0;
      r_note_idx  <= '0;
      r_note_last <= 1'b0;
      r_tone      <= '0;
      r_level     <= '0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pending   <= w_pending_nx;
      r_muted     <= w_muted_nx;
      r_cnt       <= w_cnt_nx;
      r_step      <= w_step_nx;
      r_sfx_id    <= w_sfx_id_nx;
      r_note_idx  <= w_note_idx_nx;
      r_note_last <= w_rom_last;
      r_tone      <= w_tone_nx;
      r_level     <= (w_tone_nx != '0) ? volume : 3'd0;
      r_active    <= (w_state_nx == ST_SFX);
    end
  end

  assign music_step = r_step;
  assign tone_hz    = r_tone;
  assign tone_level = r_level;
  assign sfx_active = r_active;
  assign sfx_id     = r_sfx_id;

endmodule
`default_nettype wire

// File: tb/tb_sound_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_sound_scheduler
// Brief  : Randomised and directed bench against a note-table reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sound_scheduler;

  localparam int MT  = 10;
  localparam int ST  = 4;
  localparam int LEN = 75;
  localparam int M_IDLE = 0, M_MUSIC = 1, M_SFX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        music_en;
  logic [3:0]  sfx_req;
  logic [10:0] music_hz;
  logic [2:0]  volume;
  logic [6:0]  music_step;
  logic [10:0] tone_hz;
  logic [2:0]  tone_level;
  logic        sfx_active;
  logic [1:0]  sfx_id;

  int n_checks = 0;
  int n_errors = 0;

  sound_scheduler #(.MUSIC_TICK(MT), .SFX_TICK(ST), .MUSIC_LEN(LEN)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .music_en   (music_en),
    .sfx_req    (sfx_req),
    .music_hz   (music_hz),
    .volume     (volume),
    .music_step (music_step),
    .tone_hz    (tone_hz),
    .tone_level (tone_level),
    .sfx_active (sfx_active),
    .sfx_id     (sfx_id)
  );

  always #5 clk = ~clk;

  // External melody ROM stand-in, with a rest every seventh step
  function automatic int mel(input int s);
    return (s % 7 == 3) ? 0 : 100 + (s * 29) % 1900;
  endfunction
  assign music_hz = 11'(mel(int'(music_step)));

  int tab [4][6] = '{'{784, 988, 0, 0, 0, 0},
                     '{330, 262, 0, 0, 0, 0},
                     '{523, 659, 784, 1047, 0, 0},
                     '{659, 587, 523, 494, 440, 415}};
  int tlen [4] = '{2, 2, 4, 6};

  int         m_mode, m_left, m_step, m_id, m_note;
  logic [3:0] m_pend;
  bit         m_muted;
  int         e_tone, e_level, e_act;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_step = 0; m_id = 0; m_note = 0;
    m_pend = '0; m_muted = 0; e_tone = 0; e_level = 0; e_act = 0;
  endtask

  // One clock edge of the reference: notes last a whole number of cycles (m_left)
  task automatic model_step(input logic [3:0] req, input logic en, input logic [2:0] vol);
    int hi, prev_step;
    bit start, go_done;
    hi = 0;
    for (int b = 0; b < 4; b++) if (m_pend[b]) hi = b;
    start = 0; go_done = 0; prev_step = m_step;
    if (m_pend != 0 && (m_mode != M_SFX || hi > m_id)) begin
      start = 1;
    end else if (m_mode == M_IDLE) begin
      if (en && !m_muted) begin m_mode = M_MUSIC; m_left = MT; end
    end else if (m_mode == M_MUSIC) begin
      if (!en) m_mode = M_IDLE;
      else if (m_left == 1) begin m_step = (m_step + 1) % LEN; m_left = MT; end
      else m_left--;
    end else begin
      if (m_left > 1) m_left--;
      else if (m_note + 1 < tlen[m_id]) begin m_note++; m_left = ST; end
      else begin
        go_done = (m_id == 3);
        if (m_pend != 0) start = 1;
        else if (en && !m_muted && !go_done) begin m_mode = M_MUSIC; m_left = MT; end
        else m_mode = M_IDLE;
      end
    end
    if (start) begin
      m_mode = M_SFX; m_id = hi; m_note = 0; m_left = ST; m_pend[hi] = 1'b0;
    end
    m_pend  = m_pend | req;
    m_muted = go_done || (m_muted && en);
    if (!en) m_step = 0;
    e_tone  = (m_mode == M_SFX) ? tab[m_id][m_note] :
              (m_mode == M_MUSIC) ? mel(prev_step) : 0;
    e_level = (e_tone != 0) ? int'(vol) : 0;
    e_act   = (m_mode == M_SFX) ? 1 : 0;
  endtask

  task automatic compare();
    chk("tone_hz",    32'(tone_hz),    e_tone);
    chk("tone_level", 32'(tone_level), e_level);
    chk("music_step", 32'(music_step), m_step);
    chk("sfx_active", 32'(sfx_active), e_act);
    if (e_act != 0) chk("sfx_id", 32'(sfx_id), m_id);
  endtask

  task automatic tick(input logic [3:0] req);
    sfx_req = req;
    @(posedge clk);
    model_step(req, music_en, volume);
    @(negedge clk);
    sfx_req = 4'd0;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(4'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tone_hz"},    32'(tone_hz),    0);
    chk({tag, "_tone_level"}, 32'(tone_level), 0);
    chk({tag, "_sfx_active"}, 32'(sfx_active), 0);
    chk({tag, "_sfx_id"},     32'(sfx_id),     0);
    chk({tag, "_music_step"}, 32'(music_step), 0);
  endtask

  initial begin
    rst = 1'b0; music_en = 1'b0; sfx_req = 4'd0; volume = 3'd5;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b1;

    // Melody from step 0 through the 74 -> 0 wrap
    music_en = 1'b1;
    run(LEN * MT + 20);

    // Rotate during step 5, then resume step 5
    for (int i = 0; i < 2 * LEN * MT; i++) begin
      if (m_mode == M_MUSIC && m_step == 5 && m_left == 6) break;
      tick(4'd0);
    end
    tick(4'b0001);
    run(30);

    // Drop preempts the first rotate note
    tick(4'b0001);
    tick(4'd0);
    tick(4'b0010);
    run(30);

    // Line clear and rotate together
    tick(4'b0101);
    run(45);

    // Game over mutes, music_en low clears the mute
    volume = 3'd7;
    tick(4'b1000);
    run(35);
    music_en = 1'b0;
    run(3);
    music_en = 1'b1;
    run(25);

    // Randomised requests, enables and volume
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] req;
      if ($urandom_range(0, 149) == 0) music_en = ~music_en;
      if ($urandom_range(0, 9) == 0) volume = 3'($urandom);
      req = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      tick(req);
    end

    // Reset in the middle of an SFX with another request pending
    music_en = 1'b0;
    run(3);
    music_en = 1'b1;
    tick(4'b0100);
    run(3);
    tick(4'b0001);
    run(1);
    #2 rst = 1'b0;
    #1 chk_zero_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("held_rst");
    rst = 1'b1;
    model_reset();
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 Parameter MUSIC_TICK, default 25_000_000: clk cycles per music note.
REQ-002 Parameter SFX_TICK, default 2_500_000: clk cycles per sound-effect note.
REQ-003 Parameter MUSIC_LEN, default 75: melody steps; index range 0..MUSIC_LEN-1.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 music_en  in  1  background melody enable.
REQ-007 sfx_req  in  4  single-cycle request pulses: bit0 rotate, bit1 drop, bit2 line_clear, bit3 game_over.
REQ-008 music_hz  in  11  frequency of step music_step, returned combinationally by the external melody ROM; 0 = rest.
REQ-009 volume  in  3  output level for the tone generator.
REQ-010 music_step  out  7  current melody index.
REQ-011 tone_hz  out  11  frequency for the shared tone generator; 0 = silence.
REQ-012 tone_level  out  3  level for the tone generator.
REQ-013 sfx_active  out  1  high while in SFX state.
REQ-014 sfx_id  out  2  ID of the SFX being played; valid only when sfx_active is high.

Function
REQ-015 States SHALL be IDLE, MUSIC and SFX; all outputs SHALL be registered.
REQ-016 pending[3:0] SHALL be set by sfx_req at each edge; a bit SHALL clear when its SFX starts; set and clear of the same bit in one cycle SHALL leave the bit set.
REQ-017 Priority SHALL be game_over > line_clear > drop > rotate.
REQ-018 SFX entry: pending nonzero and (state != SFX, or highest pending ID > sfx_id) SHALL enter SFX at the next edge, with sfx_id = highest pending ID, note index 0 and the duration counter loaded with SFX_TICK-1.
REQ-019 An equal- or lower-priority request during SFX SHALL stay pending; a preempted SFX SHALL be discarded, not resumed.
REQ-020 SFX note tables (Hz, SFX_TICK each): rotate 784,988; drop 330,262; line_clear 523,659,784,1047; game_over 659,587,523,494,440,415.
REQ-021 Expiry of the last SFX note SHALL go to SFX (pending nonzero), else MUSIC (music_en=1 and not muted), else IDLE.
REQ-022 Pending arbitration SHALL take precedence over any note expiry in the same cycle.
REQ-023 IDLE -> MUSIC SHALL occur when music_en=1, pending=0 and muted=0.
REQ-024 In MUSIC, tone_hz = music_hz; at duration expiry music_step SHALL advance, wrapping MUSIC_LEN-1 -> 0, with the counter reloaded to MUSIC_TICK-1.
REQ-025 music_step SHALL freeze during SFX; a resumed step SHALL replay with full MUSIC_TICK duration.
REQ-026 music_en=0 SHALL force music_step to 0; MUSIC with music_en=0 SHALL go to IDLE at the next edge.
REQ-027 Completion of game_over SHALL set muted; muted SHALL clear only while music_en=0.
REQ-028 tone_hz SHALL be 0 in IDLE; tone_level SHALL equal volume when tone_hz != 0, else 0.
REQ-029 Latency: sfx_req high in cycle k -> first SFX note on tone_hz after edge k+1.

Reset
REQ-030 rst low SHALL asynchronously force IDLE: pending=0, muted=0, counter=0, music_step=0, tone_hz=0, tone_level=0, sfx_active=0, sfx_id=0; reset mid-note SHALL silence immediately.

Structure
REQ-031 A shared package SHALL hold: the state enum, SFX ID constants, note frequency constants and the default tick values.
REQ-032 Sub-module sfx_rom SHALL map (sfx_id, note index) to (hz, last_note flag); the melody ROM SHALL remain external.

Verification (MUSIC_TICK=10, SFX_TICK=4, MUSIC_LEN=75)
REQ-033 Set music_en=1 after reset -> tone_hz=music_hz(step 0); step advances every 10 cycles; 74 wraps to 0.
REQ-034 Pulse rotate during step 5 -> tone_hz 784 x4 cycles, then 988 x4, then step 5 for 10 cycles, sfx_active high only during the 8 SFX cycles.
REQ-035 Pulse drop during the first rotate note -> 330 appears at edge k+1, then 262; rotate is not resumed; music resumes.
REQ-036 Pulse line_clear and rotate in the same cycle -> 523,659,784,1047, then 784,988, then music.
REQ-037 Pulse game_over -> 659..415 (6 notes), then IDLE with music_en=1; drop music_en, then raise it -> music from step 0.
REQ-038 Assert rst low mid-SFX -> all outputs 0 in the same cycle; after release, IDLE with pending=0.
